// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and sizing for the serial-to-parallel frame path.
// Optional parity stage is enabled by S2P_PARITY_CHECK_EN.
package s2p_pkg;

  localparam int S2P_N = 4;
  localparam int S2P_W = 2 ** S2P_N;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PAR,
    LOAD,
    HOLD
  } state_t;

endpackage

// File: rtl/s2p_frame_ctrl_if.sv
// s2p_frame_ctrl_if: serial input, word handshake and status bundle.
// Parity status is only live when S2P_PARITY_CHECK_EN is defined.
interface s2p_frame_ctrl_if
  import s2p_pkg::*;
#(
  parameter int N = S2P_N
);

  localparam int W = 2 ** N;

  logic         start;
  logic         sdata;
  logic         sdata_vld;
  logic         word_rdy;
  logic [W-1:0] par_data;
  logic         load_en;
  logic         word_vld;
  logic         busy;
  logic [N:0]   bit_cnt;
  logic         overrun;
  logic         parity_err;

  modport master (
    output start, sdata, sdata_vld, word_rdy,
    input  par_data, load_en, word_vld, busy,
    input  bit_cnt, overrun, parity_err
  );

  modport slave (
    input  start, sdata, sdata_vld, word_rdy,
    output par_data, load_en, word_vld, busy,
    output bit_cnt, overrun, parity_err
  );

endinterface

// File: rtl/s2p_shift_reg.sv
// s2p_shift_reg: W-bit MSB-first shift register with shift enable.
// Used unchanged with or without S2P_PARITY_CHECK_EN.
module s2p_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_data;

  // shift the new bit in at the LSB end when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= {r_data[W-2:0], i_bit};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/s2p_frame_ctrl.sv
// s2p_frame_ctrl: frames serial bits into a word, pulses the bank load
// and holds the word on a valid/ready handshake. Macro: S2P_PARITY_CHECK_EN.
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter int N = S2P_N
) (
  input logic             clk,
  input logic             rst,
  s2p_frame_ctrl_if.slave bus
);

  localparam int         W        = 2 ** N;
  localparam logic [N:0] CNT_LAST = (N+1)'(W - 1);
  localparam logic [N:0] CNT_ONE  = (N+1)'(1);

  state_t       r_state;
  state_t       w_next;
  logic [N:0]   r_cnt;
  logic [N:0]   w_cnt;
  logic         w_shift;
  logic         r_load;
  logic         w_load;
  logic         r_vld;
  logic         w_vld;
  logic         r_ovr;
  logic         w_ovr;
  logic [W-1:0] w_data;
`ifdef S2P_PARITY_CHECK_EN
  logic         r_perr;
  logic         w_perr;
`endif

  s2p_shift_reg #(
    .W(W)
  ) u_sr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_shift),
    .i_bit (bus.sdata),
    .o_data(w_data)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state plus next values of the registered outputs
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_vld   = r_vld;
    w_ovr   = 1'b0;
`ifdef S2P_PARITY_CHECK_EN
    w_perr  = r_perr;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = SHIFT;
          w_cnt  = '0;
        end
      end
      SHIFT: begin
        // a restart wins over the bit offered in the same cycle
        if (bus.start) begin
          w_cnt = '0;
        end else if (bus.sdata_vld) begin
          w_shift = 1'b1;
          w_cnt   = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
`ifdef S2P_PARITY_CHECK_EN
            w_next = PAR;
`else
            w_next = LOAD;
            w_load = 1'b1;
`endif
          end
        end
      end
`ifdef S2P_PARITY_CHECK_EN
      PAR: begin
        // parity bit is checked against the word, never shifted in
        if (bus.start) begin
          w_next = SHIFT;
          w_cnt  = '0;
        end else if (bus.sdata_vld) begin
          w_next = LOAD;
          w_load = 1'b1;
          w_perr = (^w_data) ^ bus.sdata;
        end
      end
`endif
      LOAD: begin
        w_next = HOLD;
        w_vld  = 1'b1;
      end
      HOLD: begin
        w_ovr = bus.start;
        if (bus.word_rdy) begin
          w_next = IDLE;
          w_vld  = 1'b0;
          w_cnt  = '0;
`ifdef S2P_PARITY_CHECK_EN
          w_perr = 1'b0;
`endif
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_load <= 1'b0;
      r_vld  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt;
      r_load <= w_load;
      r_vld  <= w_vld;
      r_ovr  <= w_ovr;
    end
  end

`ifdef S2P_PARITY_CHECK_EN
  // parity verdict captured with the load, cleared on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_perr;
    end
  end

  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.par_data = w_data;
  assign bus.load_en  = r_load;
  assign bus.word_vld = r_vld;
  assign bus.busy     = (r_state != IDLE);
  assign bus.bit_cnt  = r_cnt;
  assign bus.overrun  = r_ovr;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// tb_s2p_frame_ctrl: directed and random frames against a bit-history model.
// Build with S2P_PARITY_CHECK_EN to exercise the parity stage.
module tb_s2p_frame_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  s2p_frame_ctrl_if #(.N(N)) bus ();

  s2p_frame_ctrl #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: frame phase flags, bit history since reset, expected outputs
  bit m_collect, m_wpar, m_load, m_vld, m_ovr, m_perr;
  int m_cnt;
  bit hist[$];
  int n_load = 0;
  int n_ovr  = 0;
  bit s_st, s_sd, s_sv, s_rdy;

  function automatic logic [15:0] hist_word();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i]) v = v | (16'(1) << (hist.size() - 1 - i));
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_collect = 0; m_wpar = 0; m_load = 0; m_vld = 0;
      m_ovr = 0; m_perr = 0; m_cnt = 0;
      hist.delete();
    end else begin
      s_st = bus.start; s_sd = bus.sdata;
      s_sv = bus.sdata_vld; s_rdy = bus.word_rdy;
      m_ovr = s_st && m_vld;
      if (m_load) begin
        m_load = 0;
        m_vld  = 1;
      end else if (m_vld) begin
        if (s_rdy) begin
          m_vld = 0; m_cnt = 0; m_perr = 0;
        end
      end else if (m_collect) begin
        if (s_st) begin
          m_cnt = 0;
        end else if (s_sv) begin
          hist.push_back(s_sd);
          if (hist.size() > W) void'(hist.pop_front());
          m_cnt++;
          if (m_cnt == W) begin
            m_collect = 0;
`ifdef S2P_PARITY_CHECK_EN
            m_wpar = 1;
`else
            m_load = 1;
`endif
          end
        end
      end else if (m_wpar) begin
        if (s_st) begin
          m_cnt = 0; m_wpar = 0; m_collect = 1;
        end else if (s_sv) begin
          m_perr = (^hist_word()) ^ s_sd;
          m_wpar = 0; m_load = 1;
        end
      end else if (s_st) begin
        m_collect = 1;
        m_cnt = 0;
      end
    end
    #1;
    chk("par_data", bus.par_data, hist_word());
    chk("load_en", bus.load_en, m_load);
    chk("word_vld", bus.word_vld, m_vld);
    chk("busy", bus.busy, m_collect | m_wpar | m_load | m_vld);
    chk("bit_cnt", bus.bit_cnt, m_cnt);
    chk("overrun", bus.overrun, m_ovr);
    chk("parity_err", bus.parity_err, m_perr);
    if (bus.load_en === 1'b1) n_load++;
    if (bus.overrun === 1'b1) n_ovr++;
  end

  task automatic cyc(input bit st, input bit sd, input bit sv, input bit rdy);
    bus.start = st; bus.sdata = sd; bus.sdata_vld = sv; bus.word_rdy = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic bits(input logic [15:0] w, input bit stall, input bit pb);
    for (int i = W - 1; i >= 0; i--) begin
      if (stall) cyc(0, 1'($urandom), 0, 0);
      cyc(0, w[i], 1, 0);
    end
`ifdef S2P_PARITY_CHECK_EN
    cyc(0, pb, 1, 0);
`else
    if (pb) begin end
`endif
  endtask

  task automatic send(input logic [15:0] w, input bit stall, input bit pb);
    cyc(1, 1'($urandom), 1, 0);
    bits(w, stall, pb);
  endtask

  task automatic finish_word();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
  endtask

  int l0, o0;

  initial begin
    bus.start = 0; bus.sdata = 0; bus.sdata_vld = 0; bus.word_rdy = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_par", bus.par_data, 16'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_vld", bus.word_vld, 1'b0);
    chk("rst_cnt", bus.bit_cnt, 5'd0);
    rst = 0;
    cyc(0, 1, 1, 1);
    chk("idle_ignore_cnt", bus.bit_cnt, 5'd0);

    l0 = n_load;
    send(16'hA5C3, 0, 1'b0);
    chk("nom_load_en", bus.load_en, 1'b1);
    chk("nom_par", bus.par_data, 16'hA5C3);
    chk("nom_cnt", bus.bit_cnt, 5'd16);
    cyc(0, 0, 0, 1);
    chk("nom_vld", bus.word_vld, 1'b1);
    chk("nom_load_off", bus.load_en, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("nom_busy", bus.busy, 1'b0);
    chk("nom_loads", n_load - l0, 1);

    l0 = n_load;
    send(16'hA5C3, 1, 1'b0);
    chk("stall_load_en", bus.load_en, 1'b1);
    chk("stall_par", bus.par_data, 16'hA5C3);
    finish_word();
    chk("stall_loads", n_load - l0, 1);

    l0 = n_load;
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1'($urandom), 1, 0);
    cyc(1, 1, 1, 0);
    chk("abort_cnt", bus.bit_cnt, 5'd0);
    bits(16'h1234, 0, 1'b1);
    chk("abort_par", bus.par_data, 16'h1234);
    cyc(0, 0, 0, 0);
    chk("abort_loads", n_load - l0, 1);

    o0 = n_ovr;
    for (int k = 0; k < 10; k++) cyc(k == 5, 1'($urandom), 1, 0);
    chk("ovr_vld", bus.word_vld, 1'b1);
    chk("ovr_pulses", n_ovr - o0, 1);
    cyc(0, 0, 0, 1);
    chk("ovr_idle", bus.busy, 1'b0);
    cyc(0, 1, 1, 0);
    chk("ovr_nostart", bus.busy, 1'b0);

    send(16'h5A5A, 0, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("ovr_rdy_busy", bus.busy, 1'b0);
    chk("ovr_rdy_pulse", bus.overrun, 1'b1);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0);
    #2;
    rst = 1;
    #1;
    chk("mrst_par", bus.par_data, 16'h0);
    chk("mrst_cnt", bus.bit_cnt, 5'd0);
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_load", bus.load_en, 1'b0);
    chk("mrst_vld", bus.word_vld, 1'b0);
    chk("mrst_ovr", bus.overrun, 1'b0);
    chk("mrst_perr", bus.parity_err, 1'b0);
    @(posedge clk);
    #2;
    rst = 0;
    send(16'hFFFF, 0, 1'b0);
    chk("ffff_par", bus.par_data, 16'hFFFF);
    chk("ffff_load", bus.load_en, 1'b1);
    finish_word();

`ifdef S2P_PARITY_CHECK_EN
    send(16'h0001, 0, 1'b1);
    chk("par_good", bus.parity_err, 1'b0);
    finish_word();
    send(16'h0001, 0, 1'b0);
    chk("par_bad", bus.parity_err, 1'b1);
    chk("par_bad_load", bus.load_en, 1'b1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("par_bad_held", bus.parity_err, 1'b1);
    cyc(0, 0, 0, 1);
    chk("par_clear", bus.parity_err, 1'b0);
`endif

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 19) == 0, 1'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
- Sequencer for the serial-to-parallel (S2P) path.
- Accepts a framed serial bit stream MSB-first and assembles it into a 2**N-bit word in an internal shift register.
- Drives the clock-enable of the downstream 16-bit enable-register bank with a one-cycle load pulse.
- Presents the captured word to the consumer over a valid/ready handshake and flags protocol violations.

Parameters:
- N, 4, log2 of word width; word width W = 2**N (default 16).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start strobe.
- sdata  in  1  serial data bit.
- sdata_vld  in  1  sdata qualifier; one bit accepted per cycle when high.
- par_data  out  W  shift-register contents; wired to the register bank data input.
- load_en  out  1  one-cycle enable pulse to the register bank.
- word_vld  out  1  captured word available in the register bank.
- word_rdy  in  1  consumer accepts the word.
- busy  out  1  high in any state other than IDLE.
- bit_cnt  out  N+1  bits accepted in the current frame.
- overrun  out  1  one-cycle pulse: start seen while word_vld is high.
- parity_err  out  1  parity result for the held word (see Optional Feature).

Behaviour:
- Reset (async, immediate, also mid-frame):
  - State goes to IDLE.
  - par_data=0, bit_cnt=0, load_en=0, word_vld=0, busy=0, overrun=0, parity_err=0.
- States are IDLE, SHIFT, (PAR), LOAD, HOLD. Outputs are registered except busy, which decodes state.
- IDLE:
  - sdata_vld is ignored.
  - start=1 moves to SHIFT and clears bit_cnt.
  - A bit presented in the start cycle is not captured; the first data bit is the next cycle with sdata_vld=1.
- SHIFT:
  - On each sdata_vld=1: par_data <= {par_data[W-2:0], sdata}, bit_cnt increments.
  - sdata_vld=0 stalls with no change.
  - On accepting bit W (bit_cnt==W-1 with sdata_vld=1), go to LOAD, or to PAR when the macro is defined.
  - start=1 in SHIFT aborts the frame: bit_cnt <= 0, par_data kept but overwritten as new bits arrive, stay in SHIFT. start takes priority over sdata_vld in the same cycle; that bit is dropped.
- LOAD:
  - Exactly one cycle with load_en=1; par_data is stable.
  - Next state is HOLD, with word_vld <= 1.
  - Latency: load_en is high the cycle after the last bit is accepted; word_vld is high one cycle after that.
- HOLD:
  - word_vld stays high until word_rdy=1, then return to IDLE with word_vld <= 0 and bit_cnt <= 0.
  - word_rdy is ignored whenever word_vld=0.
  - start in HOLD: overrun pulses for 1 cycle and start is otherwise ignored. The frame is not begun.
  - start and word_rdy in the same cycle: accept the handshake, pulse overrun, go to IDLE.
- load_en never asserts outside LOAD. par_data does not change in LOAD or HOLD.
- bit_cnt saturates at W and never wraps.

Optional Feature:
- Macro: S2P_PARITY_CHECK_EN.
- Defined:
  - After bit W, state PAR waits for one extra sdata_vld bit (the even-parity bit) and does not shift it into par_data.
  - parity_err <= (^par_data) ^ parity_bit, registered on entering LOAD and held through HOLD.
  - parity_err clears on leaving HOLD.
  - The word is still loaded when parity_err=1.
  - start in PAR aborts exactly as in SHIFT.
- Undefined: no PAR state, and parity_err is tied to 0. The port list is unchanged.

Decomposition:
- Shared package s2p_pkg: state enum (IDLE, SHIFT, PAR, LOAD, HOLD) and a localparam for W derived from N.
- One sub-module is natural: s2p_shift_reg, a W-bit MSB-first shift register with shift enable.
- The FSM, counter and handshake logic stay in the top module.

Test Plan:
- Nominal: start, then 16 valid bits 0xA5C3 back-to-back → load_en pulses exactly once, 1 cycle after the 16th bit; par_data=0xA5C3; word_vld high the next cycle; word_rdy returns busy=0.
- Stalls: same word with sdata_vld low on every other cycle → same par_data; bit_cnt increments only on valid cycles; load_en timing relative to the last bit is unchanged.
- Abort: 7 bits, then start asserted with sdata_vld=1, then 16 bits 0x1234 → that bit is dropped; par_data=0x1234; a single load_en.
- Backpressure/overrun: hold word_rdy=0 for 10 cycles and pulse start at cycle 5 → overrun is high for exactly 1 cycle; word_vld stays high; after word_rdy the FSM returns to IDLE and no frame has started.
- Reset mid-frame: assert rst after 9 bits, asynchronously between edges → all outputs are 0 immediately; a later full frame 0xFFFF captures correctly.
- With S2P_PARITY_CHECK_EN: 0x0001 with parity bit 1 → parity_err=0; with parity bit 0 → parity_err=1, held until word_rdy.
